// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package instruction_loader_pkg;

    // Width of the little-endian word-count header.
    localparam int unsigned LEN_W          = 16;
    // Bytes that make up one instruction word.
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_e;

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream handshake plus instruction-memory write port.
interface instruction_loader_if #(
    parameter int ADDR_W = 6
) ();

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    // Loader side: consumes the stream, drives the memory write port.
    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_we,
        output mem_waddr,
        output mem_wdata
    );

    // Environment side: byte source and memory sink.
    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_we,
        input  mem_waddr,
        input  mem_wdata
    );

endinterface

// File: rtl/instruction_loader_word_assembler.sv
// Shift register that builds a little-endian word one byte at a time.
module word_assembler
    import instruction_loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr_i,
    input  logic                          load_i,
    input  logic [7:0]                    byte_i,
    output logic [8*BYTES_PER_WORD-1:0]   word_o
);

    localparam int unsigned W = 8 * BYTES_PER_WORD;

    logic [W-1:0] word_q;

    // New bytes enter at the top and shift down, so the first byte ends in [7:0].
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            word_q <= '0;
        end else if (load_i) begin
            word_q <= {byte_i, word_q[W-1:8]};
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/instruction_loader.sv
// Boot loader: parses a length-prefixed byte stream into instruction words,
// writes them to instruction memory and holds the core in reset until done.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    instruction_loader_if.master bus,
    output logic                 core_rst,
    output logic                 done,
    output logic                 error
);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;

    logic              ready;
    logic              xfer;
    logic              asm_load;
    logic              asm_clr;
    logic [LEN_W-1:0]  len_full;
    logic              last_word;
    logic [31:0]       asm_word;

    word_assembler u_asm (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (asm_clr),
        .load_i (asm_load),
        .byte_i (bus.byte_data),
        .word_o (asm_word)
    );

    // State, header length and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        asm_load   = 1'b0;
        asm_clr    = 1'b0;

        ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
        xfer  = ready && bus.byte_valid;

        len_full  = {bus.byte_data, len_q[7:0]};
        last_word = (LEN_W'(word_cnt_q) == (len_q - LEN_W'(1)));

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN_LO;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    asm_clr    = 1'b1;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = bus.byte_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = bus.byte_data;
                    if ((len_full == '0) || (len_full > LEN_W'(DEPTH))) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    asm_load   = 1'b1;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'(BYTES_PER_WORD - 1)) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // The counter holds on the final word so the address never wraps past DEPTH-1.
                if (last_word) begin
                    state_d = S_DONE;
                end else begin
                    word_cnt_d = word_cnt_q + ADDR_W'(1);
                    state_d    = S_DATA;
                end
            end
            default: state_d = S_IDLE;
        endcase

        bus.byte_ready = ready;
        bus.mem_we     = (state_q == S_WRITE);
        core_rst       = (state_q != S_DONE);
        done           = (state_q == S_DONE);
        error          = (state_q == S_ERR);
    end

    assign bus.mem_waddr = word_cnt_q;
    assign bus.mem_wdata = asm_word;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for the instruction loader.
module tb_instruction_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic core_rst;
    logic done;
    logic error;

    int chk_total = 0;
    int chk_pass  = 0;
    int we_cnt    = 0;

    logic [ADDR_W+31:0] exp_q[$];
    logic [31:0]        tb_mem [0:DEPTH-1];

    instruction_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instruction_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .core_rst (core_rst),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_total++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            chk_pass++;
        end
    endtask

    // Memory sink and scoreboard: every write must match the oldest expected entry.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            logic [ADDR_W+31:0] e;
            we_cnt++;
            tb_mem[bus.mem_waddr] = bus.mem_wdata;
            chk("ready_in_write", 64'(bus.byte_ready), 64'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_we", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("waddr", 64'(bus.mem_waddr), 64'(e[ADDR_W+31:32]));
                chk("wdata", 64'(bus.mem_wdata), 64'(e[31:0]));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (!bus.byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'hxx;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, input logic [ADDR_W-1:0] addr);
        logic [31:0] sh;
        exp_q.push_back({addr, w});
        sh = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(sh[7:0], gap);
            sh = sh >> 8;
        end
    endtask

    task automatic send_header(input logic [15:0] n);
        send_byte(n[7:0], 0);
        send_byte(n[15:8], 0);
    endtask

    task automatic load(input int n, input int gap);
        send_header(16'(n));
        for (int i = 0; i < n; i++) send_word($urandom, gap, ADDR_W'(i));
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && !error && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(done), 64'd1);
        chk({tag, "_core_rst"}, 64'(core_rst), 64'd0);
        chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          we0;
        logic [31:0] w0;

        rst            = 1'b1;
        start          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_ready",    64'(bus.byte_ready), 64'd0);
        chk("rst_we",       64'(bus.mem_we),     64'd0);
        chk("rst_waddr",    64'(bus.mem_waddr),  64'd0);
        chk("rst_wdata",    64'(bus.mem_wdata),  64'd0);
        chk("rst_core_rst", 64'(core_rst),       64'd1);
        chk("rst_done",     64'(done),           64'd0);
        chk("rst_error",    64'(error),          64'd0);

        // Normal single-word load with exact latency
        do_start();
        chk("t1_ready_lenlo", 64'(bus.byte_ready), 64'd1);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        exp_q.push_back({ADDR_W'(0), 32'h0061F4B3});
        send_byte(8'hB3, 0);
        send_byte(8'hF4, 0);
        send_byte(8'h61, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        chk("t1_we_pulse",      64'(bus.mem_we), 64'd1);
        chk("t1_core_rst_held", 64'(core_rst),   64'd1);
        chk("t1_done_early",    64'(done),       64'd0);
        @(negedge clk);
        chk("t1_done",     64'(done),          64'd1);
        chk("t1_core_rst", 64'(core_rst),      64'd0);
        chk("t1_sb_empty", 64'(exp_q.size()),  64'd0);

        // Three words with byte_valid toggling
        we0 = we_cnt;
        do_start();
        load(3, 1);
        wait_done("t2_done");
        chk("t2_we_count", 64'(we_cnt - we0), 64'd3);

        // Bad lengths: zero and DEPTH+1
        we0 = we_cnt;
        do_start();
        chk("t3_done_cleared", 64'(done), 64'd0);
        send_header(16'h0000);
        @(negedge clk);
        chk("t3a_error",    64'(error),    64'd1);
        chk("t3a_core_rst", 64'(core_rst), 64'd1);
        chk("t3a_ready",    64'(bus.byte_ready), 64'd0);
        do_start();
        chk("t3_error_cleared", 64'(error), 64'd0);
        send_header(16'h0041);
        @(negedge clk);
        chk("t3b_error",    64'(error),    64'd1);
        chk("t3b_core_rst", 64'(core_rst), 64'd1);
        repeat (3) @(negedge clk);
        chk("t3_no_we", 64'(we_cnt - we0), 64'd0);

        // Reset in the middle of word 1
        do_start();
        send_header(16'd3);
        w0 = $urandom;
        send_word(w0, 0, ADDR_W'(0));
        send_byte(8'hA5, 0);
        send_byte(8'h5A, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t4_ready",    64'(bus.byte_ready), 64'd0);
        chk("t4_core_rst", 64'(core_rst),       64'd1);
        chk("t4_done",     64'(done),           64'd0);
        chk("t4_wdata",    64'(bus.mem_wdata),  64'd0);
        chk("t4_mem0",     64'(tb_mem[0]),      64'(w0));
        chk("t4_sb_empty", 64'(exp_q.size()),   64'd0);
        do_start();
        load(2, 0);
        wait_done("t4_done_after");

        // start during DATA is ignored; start in DONE reloads
        we0 = we_cnt;
        do_start();
        send_header(16'd2);
        send_word($urandom, 0, ADDR_W'(0));
        w0 = $urandom;
        exp_q.push_back({ADDR_W'(1), w0});
        send_byte(w0[7:0], 0);
        send_byte(w0[15:8], 0);
        do_start();
        chk("t5_ready_data", 64'(bus.byte_ready), 64'd1);
        send_byte(w0[23:16], 0);
        send_byte(w0[31:24], 0);
        wait_done("t5_done");
        chk("t5_we_count", 64'(we_cnt - we0), 64'd2);
        do_start();
        chk("t5_restart_core_rst", 64'(core_rst),       64'd1);
        chk("t5_restart_done",     64'(done),           64'd0);
        chk("t5_restart_ready",    64'(bus.byte_ready), 64'd1);
        load(1, 0);
        wait_done("t5_done_again");

        // Full depth
        we0 = we_cnt;
        do_start();
        load(DEPTH, 0);
        wait_done("t6_done");
        chk("t6_we_count", 64'(we_cnt - we0), 64'(DEPTH));
        chk("t6_last_addr", 64'(bus.mem_waddr), 64'(DEPTH - 1));

        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Boot-time writer for the instruction memory: accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them sequentially into the instruction memory's write port. It holds the core in reset until the image is fully written, then releases it so fetch starts from address 0 with the loaded program. It is the write-side counterpart to the fetch path's read-only instruction memory access.

## Interface
- `DEPTH`, default 64: instruction memory size in 32-bit words.
- `ADDR_W`, default 6: word-address width, equal to clog2(DEPTH).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a load. Honoured only in IDLE, DONE or ERR.
- `byte_valid` in 1: stream byte present.
- `byte_data` in 8: stream byte.
- `byte_ready` out 1: loader accepts a byte this cycle. A transfer occurs when byte_valid and byte_ready are both high.
- `mem_we` out 1: instruction memory write enable, one-cycle pulse per word.
- `mem_waddr` out ADDR_W: word address for the write.
- `mem_wdata` out 32: instruction word for the write.
- `core_rst` out 1: held high while the image is not yet valid.
- `done` out 1: load completed successfully.
- `error` out 1: length header invalid.

## Operation
- Stream format: 2-byte little-endian word count N, followed by 4·N bytes. Each instruction is little-endian, so the first byte goes to bits [7:0].
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
- IDLE: on start, go to LEN_LO.
- LEN_LO: a transfer latches N[7:0]; go to LEN_HI.
- LEN_HI: a transfer latches N[15:8]; go to DATA. If N is 0 or N > DEPTH, go to ERR instead.
- DATA: each transfer shifts a byte into the assembler and increments the byte counter (2 bits). On the 4th byte, go to WRITE.
- WRITE: mem_we=1; mem_waddr = word counter; mem_wdata = assembled word. Then increment the word counter.
  - If the word counter equals N−1, go to DONE.
  - Otherwise go back to DATA.
- DONE: done=1 and core_rst=0, held. A start pulse restarts at LEN_LO, which clears done and reasserts core_rst.
- ERR: error=1 and core_rst=1, held. A start pulse restarts at LEN_LO and clears error.
- start arriving in LEN_LO, LEN_HI, DATA or WRITE is ignored.
- byte_ready is 1 only in LEN_LO, LEN_HI and DATA. byte_data is ignored when no transfer occurs.
- The word address counts 0..N−1 with no wrap; N ≤ DEPTH guarantees this.
- Memory locations at N and above are not touched.
- The byte and word counters are cleared on every entry to LEN_LO.

## Timing
- Reset values:
  - state = IDLE
  - byte_ready = 0
  - mem_we = 0
  - mem_waddr = 0
  - mem_wdata = 0
  - core_rst = 1
  - done = 0
  - error = 0
- All outputs are registered or decoded from state only. There is no combinational path from byte_valid to any output.
- Latency: the 4th byte of a word is accepted at edge k; mem_we is high during the cycle after edge k, and the write lands at edge k+1.
- Maximum throughput is 4 bytes per 5 cycles, because byte_ready drops during WRITE.
- core_rst falls on the same edge that enters DONE, one cycle after the final mem_we pulse.
- Reset asserted mid-load:
  - Return to IDLE; any partial word is discarded.
  - Words already written stay in memory.
  - core_rst returns to 1.
- Reset dominates start when both are high.

## Structure
- Shared package contents:
  - state enum encoding (7 states, 3 bits)
  - length-field width constant LEN_W = 16
  - bytes-per-word constant = 4
- Sub-module `word_assembler`: 32-bit shift register with load/clear, filled LSB-first. This keeps the FSM independent of byte ordering.
- Parent contents: FSM, counters, and the length-check compare.

## Test plan
- Normal load: start, then stream 01 00 B3 F4 61 00 → single write with mem_waddr=0 and mem_wdata=32'h0061F4B3. done=1 and core_rst=0 one cycle after mem_we.
- Three-word load with byte_valid toggling every other cycle: writes land at addresses 0, 1, 2 in order. Word contents match the bytes, and byte_ready=0 during every WRITE cycle.
- Bad length, header 00 00 and header 41 00 (65 > DEPTH): ERR is entered after the 2nd byte, error=1, core_rst stays 1, and mem_we never pulses.
- Reset after 2 of 4 data bytes of word 1: returns to IDLE with byte_ready=0 and core_rst=1. Word 0 remains written. A fresh start and full stream then completes normally.
- start pulsed during DATA is ignored, and the load completes with the original N. start in DONE reasserts core_rst and accepts a new header.
- Full depth: N=64 gives 64 writes at addresses 0..63 and no address wrap, then done=1.
